pixel_write_queue: RTL and testbench



---
 rtl/pixel_write_queue.sv | 142 ++++++++++++++
 tb/tb_pixel_write_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_queue.sv
// Generic synchronous show-ahead FIFO with flush and occupancy count.
// Latency: an entry written at cycle N is presented on rd_dat at cycle N+1; head is read combinationally.
// Backpressure: the caller asserts wr_vld only when !full or when popping in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   rd_rdy,
    output logic                   rd_vld,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count_nxt;
    logic             do_pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_pop = rd_rdy && rd_vld;

    always_comb begin
        count_nxt = count;
        if (wr_vld && !do_pop) begin
            count_nxt = count + (PW+1)'(1);
        end else if (!wr_vld && do_pop) begin
            count_nxt = count - (PW+1)'(1);
        end
    end

    // Storage is cleared on reset so the head outputs read zero until the first write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (PW+1)'(DEPTH));
        end
    end
endmodule

// Pixel write queue: maps (x, y, data) writes to frame-buffer addresses and buffers them for the SRAM.
// Latency: an accepted write is presented on sram_write_* one cycle later; one entry drains per write_slot.
// Backpressure: program_full when DEPTH entries are queued; a write while full without a pop is dropped and sets overflow.
module pixel_write_queue #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 20,
    parameter int LINE_WIDTH = 640,
    parameter int LINES      = 480,
    parameter int BASE_ADDR  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             program_x,
    input  logic [9:0]             program_y,
    input  logic [15:0]            program_data,
    input  logic                   program_write,
    input  logic                   flush,
    output logic                   program_full,
    input  logic                   write_slot,
    output logic                   sram_write_req,
    output logic [ADDR_WIDTH-1:0]  sram_write_addr,
    output logic [15:0]            sram_write_data,
    output logic [$clog2(DEPTH):0] pending_count,
    output logic                   overflow
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           data;
    } entry_t;

    entry_t enq_entry;
    entry_t head_entry;
    logic   in_range;
    logic   pop;
    logic   push;
    logic   drop;

    assign in_range = (32'(program_x) < 32'(LINE_WIDTH)) && (32'(program_y) < 32'(LINES));

    // Constant multiply by LINE_WIDTH reduces to shift-add; result is truncated to the SRAM address width.
    assign enq_entry.addr = ADDR_WIDTH'(32'(BASE_ADDR) + 32'(program_y) * 32'(LINE_WIDTH) + 32'(program_x));
    assign enq_entry.data = program_data;

    assign pop  = write_slot && sram_write_req;
    assign push = program_write && in_range && (!program_full || pop);
    assign drop = program_write && in_range && program_full && !pop;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .wr_vld (push),
        .wr_dat (enq_entry),
        .rd_rdy (write_slot),
        .rd_vld (sram_write_req),
        .rd_dat (head_entry),
        .count  (pending_count),
        .full   (program_full)
    );

    assign sram_write_addr = head_entry.addr;
    assign sram_write_data = head_entry.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pixel_write_queue.sv
// Randomized and directed bench for pixel_write_queue with a queue-based reference model and scoreboard.
module tb_pixel_write_queue;
    localparam int DEPTH = 16;
    localparam int AW    = 20;
    localparam int LW    = 640;
    localparam int NL    = 480;
    localparam int BASE  = 0;

    logic          clk           = 1'b0;
    logic          reset         = 1'b1;
    logic [9:0]    program_x     = '0;
    logic [9:0]    program_y     = '0;
    logic [15:0]   program_data  = '0;
    logic          program_write = 1'b0;
    logic          flush         = 1'b0;
    logic          write_slot    = 1'b0;
    logic          program_full;
    logic          sram_write_req;
    logic [AW-1:0] sram_write_addr;
    logic [15:0]   sram_write_data;
    logic [4:0]    pending_count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } exp_t;

    exp_t sb_q[$];
    int   m_cnt = 0;
    bit   m_ovf = 1'b0;

    pixel_write_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .LINES      (NL),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .program_x       (program_x),
        .program_y       (program_y),
        .program_data    (program_data),
        .program_write   (program_write),
        .flush           (flush),
        .program_full    (program_full),
        .write_slot      (write_slot),
        .sram_write_req  (sram_write_req),
        .sram_write_addr (sram_write_addr),
        .sram_write_data (sram_write_data),
        .pending_count   (pending_count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input int x, input int y, input logic [15:0] d);
        program_write = w;
        program_x     = 10'(x);
        program_y     = 10'(y);
        program_data  = d;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 16'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"},   32'(sram_write_req), 32'd0);
        check({tag, "_addr"},  32'(sram_write_addr), 32'd0);
        check({tag, "_data"},  32'(sram_write_data), 32'd0);
        check({tag, "_count"}, 32'(pending_count), 32'd0);
        check({tag, "_full"},  32'(program_full), 32'd0);
        check({tag, "_ovf"},   32'(overflow), 32'd0);
    endtask

    // Reference model: a queue of pending pixels updated by the rules of the interface at each edge.
    always @(posedge clk) begin : model
        bit   pop;
        bit   inr;
        bit   acc;
        int   a;
        if (reset) begin
            m_cnt = 0;
            m_ovf = 1'b0;
            sb_q.delete();
        end else if (flush) begin
            m_cnt = 0;
            sb_q.delete();
        end else begin
            pop = write_slot && (m_cnt > 0);
            inr = (int'(program_x) < LW) && (int'(program_y) < NL);
            acc = program_write && inr && ((m_cnt < DEPTH) || pop);
            if (program_write && inr && !acc) m_ovf = 1'b1;
            if (acc) begin
                a = (BASE + int'(program_y) * LW + int'(program_x)) % (1 << AW);
                sb_q.push_back('{addr: AW'(a), data: program_data});
                m_cnt = m_cnt + 1;
            end
            if (pop) m_cnt = m_cnt - 1;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard whenever the SRAM takes an entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        check("pending_count",  32'(pending_count),  32'(m_cnt));
        check("program_full",   32'(program_full),   32'(m_cnt == DEPTH));
        check("sram_write_req", 32'(sram_write_req), 32'(m_cnt != 0));
        check("overflow",       32'(overflow),       32'(m_ovf));
        if (sram_write_req && write_slot && !reset && !flush) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_unexpected: got addr 0x%0h, expected no entry", sram_write_addr);
            end else begin
                e = sb_q.pop_front();
                check("drain_addr", 32'(sram_write_addr), 32'(e.addr));
                check("drain_data", 32'(sram_write_data), 32'(e.data));
            end
        end
    end

    initial begin
        int  x;
        int  y;
        bit  w;

        tick();
        tick();
        check_reset_state("rst");
        reset = 1'b0;

        // Single write, then drain it.
        drive(1'b1, 470, 290, 16'h1234);
        tick();
        idle();
        check("t1_req",   32'(sram_write_req),  32'd1);
        check("t1_addr",  32'(sram_write_addr), 32'h2D6D6);
        check("t1_data",  32'(sram_write_data), 32'h1234);
        check("t1_count", 32'(pending_count),   32'd1);
        write_slot = 1'b1;
        tick();
        write_slot = 1'b0;
        check("t1_req_after",   32'(sram_write_req), 32'd0);
        check("t1_count_after", 32'(pending_count),  32'd0);

        // Fill to full, overflow, then drain in order.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i, 0, 16'(i));
            tick();
        end
        check("burst_full", 32'(program_full), 32'd1);
        drive(1'b1, 16, 0, 16'h0016);
        tick();
        idle();
        check("burst_ovf",   32'(overflow),      32'd1);
        check("burst_count", 32'(pending_count), 32'd16);
        write_slot = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("burst_addr", 32'(sram_write_addr), 32'(i));
            check("burst_data", 32'(sram_write_data), 32'(i));
            tick();
        end
        write_slot = 1'b0;
        check("burst_empty", 32'(sram_write_req), 32'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Push while full in a pop cycle is accepted.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i + 20, 3, 16'($urandom));
            tick();
        end
        drive(1'b1, 639, 479, 16'hFFFF);
        write_slot = 1'b1;
        tick();
        idle();
        write_slot = 1'b0;
        check("fullpp_count", 32'(pending_count), 32'd16);
        check("fullpp_ovf",   32'(overflow),      32'd0);
        write_slot = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("fullpp_last_addr", 32'(sram_write_addr), 32'h4AFFF);
        check("fullpp_last_data", 32'(sram_write_data), 32'hFFFF);
        tick();
        write_slot = 1'b0;
        check("fullpp_drained", 32'(pending_count), 32'd0);

        // Out-of-range writes are ignored.
        drive(1'b1, 640, 0, 16'hAAAA);
        tick();
        drive(1'b1, 0, 480, 16'h5555);
        tick();
        idle();
        check("oor_count", 32'(pending_count),  32'd0);
        check("oor_req",   32'(sram_write_req), 32'd0);
        check("oor_ovf",   32'(overflow),       32'd0);

        // Flush discards queued entries and same-cycle push/pop.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i + 100, 7, 16'(i + 16'h0A00));
            tick();
        end
        drive(1'b1, 5, 5, 16'h0505);
        write_slot = 1'b1;
        flush      = 1'b1;
        tick();
        flush      = 1'b0;
        write_slot = 1'b0;
        idle();
        check("flush_count", 32'(pending_count),  32'd0);
        check("flush_req",   32'(sram_write_req), 32'd0);
        drive(1'b1, 33, 44, 16'hBEEF);
        tick();
        idle();
        check("flush_next_addr", 32'(sram_write_addr), 32'(44 * 640 + 33));
        write_slot = 1'b1;
        tick();
        write_slot = 1'b0;
        check("flush_single_drained", 32'(pending_count), 32'd0);
        check("flush_sb_left", 32'(sb_q.size()), 32'd0);

        // Random interleaved traffic with a reset in the middle.
        for (int c = 0; c < 1000; c++) begin
            if (c == 600) begin
                reset = 1'b1;
                drive(1'b1, 1, 1, 16'h1111);
                write_slot = 1'b1;
                tick();
                reset = 1'b0;
                check_reset_state("midrst");
            end
            x = int'($urandom_range(0, 700));
            y = int'($urandom_range(0, 520));
            w = ($urandom_range(0, 99) < 60);
            drive(w, x, y, 16'($urandom));
            write_slot = ($urandom_range(0, 99) < 45);
            tick();
        end
        idle();
        write_slot = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (pending_count == 0) break;
            tick();
        end
        write_slot = 1'b0;
        check("final_count", 32'(pending_count), 32'd0);
        check("final_sb_left", 32'(sb_q.size()), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
